uart_baud_gen_mc: RTL and testbench
===================================

UART_BAUD_GEN_MC -- requirements
Module: uart_baud_gen_mc

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_CH, 4, channel count, 1..8.
- DIV_W, 16, integer divisor width.
- FRAC_W, 8, fractional divisor width.
- DEFAULT_OSR, 16, oversampling ratio for osr_sel=3.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- enable, in, NUM_CH, per-channel run enable.
- cfg_valid, in, 1, config write request.
- cfg_ready, out, 1, config write accepted when high with cfg_valid.
- cfg_ch, in, 3, target channel.
- cfg_div_int, in, DIV_W, integer divisor.
- cfg_div_frac, in, FRAC_W, fractional divisor (units of 2^-FRAC_W).
- cfg_osr_sel, in, 4, OSR select.
- cfg_err, out, 1, one-cycle pulse on write to cfg_ch >= NUM_CH.
- cfg_pending, out, NUM_CH, shadow config not yet applied.
- osr_tick, out, NUM_CH, one-cycle oversample strobe.
- bit_tick, out, NUM_CH, one-cycle bit-boundary strobe.
- osr_value, out, NUM_CH*8, active OSR per channel, channel 0 in LSBs.

Function
REQ-003 OSR decode SHALL be: sel 0->16, 1->8, 2->4, 3->DEFAULT_OSR, 4..15->sel+1.
REQ-004 A div_int of 0 SHALL be treated as 1 in every use.
REQ-005 Each channel SHALL have states IDLE (enable low) and RUN (enable high); IDLE holds cnt=div_int-1, accumulator=0, phase=0, ticks low.
REQ-006 In RUN, cnt SHALL decrement each cycle; when cnt==0, osr_tick is registered high next cycle and cnt reloads period-1.
REQ-007 First osr_tick SHALL occur on the div_int-th rising edge after enable is first sampled high; div_int=1, frac=0 gives osr_tick high every cycle.
REQ-008 At each reload, period SHALL be div_int plus 1 when accumulator+div_frac >= 2^FRAC_W; the accumulator (FRAC_W+1 bits) keeps the sum minus 2^FRAC_W on overflow, otherwise the sum.
REQ-009 phase SHALL count reloads 0..OSR-1 and wrap; bit_tick SHALL assert coincident with the osr_tick whose reload had phase==OSR-1.
REQ-010 cfg_ready SHALL equal !cfg_pending[cfg_ch] combinationally, and 1 when cfg_ch >= NUM_CH.
REQ-011 An accepted write SHALL load the channel's shadow registers and set cfg_pending the next cycle.
REQ-012 A write with cfg_ch >= NUM_CH SHALL be dropped and pulse cfg_err one cycle later.
REQ-013 A pending config SHALL apply to an IDLE channel one cycle after capture.
REQ-014 A pending config SHALL apply to a RUN channel at its bit-boundary reload (the one producing bit_tick):
- bit_tick for the old bit still fires;
- the reload uses the new divisor;
- accumulator and phase clear;
- cfg_pending clears the same edge.
REQ-015 Enable dropping while pending SHALL apply the config via IDLE per REQ-013; enable dropping mid-bit SHALL abandon the bit with no tick.
REQ-016 osr_value SHALL reflect the active (not shadow) OSR.

Reset
REQ-017 rst high SHALL asynchronously clear:
- ticks, cfg_err, cfg_pending, accumulators and phases to 0;
- active and shadow div_int to 1, div_frac to 0, OSR to DEFAULT_OSR.
REQ-018 Reset mid-operation SHALL discard pending configs; after release, channels behave as freshly enabled.

Configuration
REQ-019 With macro UART_BAUD_FRAC_EN defined, REQ-008 fractional accumulation SHALL be built.
REQ-020 Without UART_BAUD_FRAC_EN, no accumulator logic SHALL exist; cfg_div_frac is ignored and period is always div_int.

Structure
REQ-021 Package uart_baud_pkg SHALL hold:
- OSR encodings and the OSR decode function;
- the per-channel config struct (div_int, div_frac, osr_sel);
- the reset-value constants.
REQ-022 Per-channel engine SHALL be sub-module uart_baud_chan, instantiated NUM_CH times; the top holds the config decode, shadows and pending flags.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- ch0 div_int=4, frac=0, osr_sel=2, enable -> osr_tick every 4 cycles, first on edge 4; bit_tick every 16 cycles.
- ch1 div_int=3, frac=128 (0.5), sel=1 -> osr periods alternate 3,4; bit_tick every 28 cycles; without macro, every 24.
- ch2 running div_int=10, sel=2; write div_int=5 mid-bit -> cfg_pending=1, cfg_ready low for ch2; old bit completes at 10-cycle spacing; post-boundary spacing 5; pending clears on that bit_tick edge.
- div_int=0 on ch3 -> osr_tick every cycle; sel=12 -> osr_value=13, bit_tick every 13 cycles.
- cfg_ch=6 with NUM_CH=4 -> cfg_err pulse, no state change; cfg_ready=1.
- rst asserted mid-bit with pending write -> all outputs 0 immediately, pending cleared, osr_value=16; first tick after release at old active divisor 1.

Source files
------------

// File: rtl/uart_baud_pkg.sv
// Shared types, OSR encodings and reset constants for the multi-channel UART baud generator.
package uart_baud_pkg;

  // Config fields are sized for the widest supported divisor; users take the low bits they need.
  localparam int unsigned DIV_W_MAX  = 32;
  localparam int unsigned FRAC_W_MAX = 16;

  localparam logic [3:0] OSR_SEL_16      = 4'd0;
  localparam logic [3:0] OSR_SEL_8       = 4'd1;
  localparam logic [3:0] OSR_SEL_4       = 4'd2;
  localparam logic [3:0] OSR_SEL_DEFAULT = 4'd3;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } chan_state_e;

  typedef struct packed {
    logic [DIV_W_MAX-1:0]  div_int;
    logic [FRAC_W_MAX-1:0] div_frac;
    logic [3:0]            osr_sel;
  } chan_cfg_t;

  localparam chan_cfg_t CFG_RESET = '{
    div_int:  DIV_W_MAX'(1),
    div_frac: '0,
    osr_sel:  OSR_SEL_DEFAULT
  };

  function automatic logic [7:0] osr_decode(logic [3:0] sel, int unsigned default_osr);
    logic [7:0] osr;
    case (sel)
      OSR_SEL_16:      osr = 8'd16;
      OSR_SEL_8:       osr = 8'd8;
      OSR_SEL_4:       osr = 8'd4;
      OSR_SEL_DEFAULT: osr = 8'(default_osr);
      default:         osr = 8'(sel) + 8'd1;
    endcase
    return osr;
  endfunction

endpackage

// File: rtl/uart_baud_chan.sv
// Single-channel baud engine: oversample counter, bit phase and active config.
// Fractional accumulation is built only when UART_BAUD_FRAC_EN is defined.
module uart_baud_chan
  import uart_baud_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned FRAC_W      = 8,
  parameter int unsigned DEFAULT_OSR = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  chan_cfg_t  shadow,
  input  logic       pending,
  output logic       apply,
  output logic       osr_tick,
  output logic       bit_tick,
  output logic [7:0] osr_value
);

  // Reload value for a divisor; zero is treated as one.
  function automatic logic [DIV_W-1:0] div_m1(logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  chan_state_e      state;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic [7:0]       phase_q, phase_d;
  logic [7:0]       osr_last;
  logic             osr_tick_q, osr_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             reload;
  logic             carry;

  assign osr_value = osr_decode(sel_q, DEFAULT_OSR);
  assign osr_last  = osr_value - 8'd1;
  assign osr_tick  = osr_tick_q;
  assign bit_tick  = bit_tick_q;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W:0]   acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;

  // acc_q stays below 2^FRAC_W, so the sum cannot overflow FRAC_W+1 bits.
  always_comb begin
    acc_sum = acc_q + (FRAC_W + 1)'(frac_q);
    carry   = acc_sum[FRAC_W];
    frac_d  = apply ? FRAC_W'(shadow.div_frac) : frac_q;
    acc_d   = acc_q;
    if (state == StIdle || apply) begin
      acc_d = '0;
    end else if (reload) begin
      acc_d = {1'b0, acc_sum[FRAC_W-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_q <= FRAC_W'(CFG_RESET.div_frac);
      acc_q  <= '0;
    end else begin
      frac_q <= frac_d;
      acc_q  <= acc_d;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^shadow.div_frac;
  assign carry       = 1'b0;
`endif

  always_comb begin
    state      = enable ? StRun : StIdle;
    apply      = 1'b0;
    reload     = 1'b0;
    div_d      = div_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    osr_tick_d = 1'b0;
    bit_tick_d = 1'b0;
    unique case (state)
      StIdle: begin
        apply = pending;
        if (pending) begin
          div_d = DIV_W'(shadow.div_int);
          sel_d = shadow.osr_sel;
        end
        cnt_d   = div_m1(div_d);
        phase_d = '0;
      end
      StRun: begin
        if (cnt_q == '0) begin
          reload     = 1'b1;
          osr_tick_d = 1'b1;
          if (phase_q == osr_last) begin
            bit_tick_d = 1'b1;
            phase_d    = '0;
            apply      = pending;
          end else begin
            phase_d = phase_q + 8'd1;
          end
          // A pending config takes over at the bit boundary with a clean accumulator.
          if (apply) begin
            div_d = DIV_W'(shadow.div_int);
            sel_d = shadow.osr_sel;
            cnt_d = div_m1(div_d);
          end else begin
            cnt_d = div_m1(div_q) + DIV_W'(carry);
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= DIV_W'(CFG_RESET.div_int);
      sel_q      <= CFG_RESET.osr_sel;
      cnt_q      <= div_m1(DIV_W'(CFG_RESET.div_int));
      phase_q    <= '0;
      osr_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      osr_tick_q <= osr_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen_mc.sv
// Multi-channel UART baud generator: config decode, shadow registers and pending flags.
// Define UART_BAUD_FRAC_EN to build fractional divisor accumulation.
module uart_baud_gen_mc
  import uart_baud_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned FRAC_W      = 8,
  parameter int unsigned DEFAULT_OSR = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div_int,
  input  logic [FRAC_W-1:0]   cfg_div_frac,
  input  logic [3:0]          cfg_osr_sel,
  output logic                cfg_err,
  output logic [NUM_CH-1:0]   cfg_pending,
  output logic [NUM_CH-1:0]   osr_tick,
  output logic [NUM_CH-1:0]   bit_tick,
  output logic [NUM_CH*8-1:0] osr_value
);

  chan_cfg_t         shadow_q [NUM_CH];
  chan_cfg_t         wr_cfg;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] apply;
  logic [7:0]        pend_ext;
  logic              ch_bad;
  logic              wr_en;
  logic              cfg_err_q;

  assign ch_bad = {1'b0, cfg_ch} >= 4'(NUM_CH);

  // Pad to the full 3-bit channel space so out-of-range channels read as not pending.
  always_comb begin
    pend_ext             = '0;
    pend_ext[NUM_CH-1:0] = pending_q;
  end

  assign cfg_ready   = ch_bad | ~pend_ext[cfg_ch];
  assign wr_en       = cfg_valid & cfg_ready & ~ch_bad;
  assign cfg_pending = pending_q;
  assign cfg_err     = cfg_err_q;

  assign wr_cfg = '{
    div_int:  DIV_W_MAX'(cfg_div_int),
    div_frac: FRAC_W_MAX'(cfg_div_frac),
    osr_sel:  cfg_osr_sel
  };

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (apply[i]) begin
        pending_d[i] = 1'b0;
      end
      if (wr_en && cfg_ch == 3'(i)) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= CFG_RESET;
      end
      pending_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && cfg_ch == 3'(i)) begin
          shadow_q[i] <= wr_cfg;
        end
      end
      pending_q <= pending_d;
      cfg_err_q <= cfg_valid & ch_bad;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    uart_baud_chan #(
      .DIV_W       (DIV_W),
      .FRAC_W      (FRAC_W),
      .DEFAULT_OSR (DEFAULT_OSR)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable[g]),
      .shadow    (shadow_q[g]),
      .pending   (pending_q[g]),
      .apply     (apply[g]),
      .osr_tick  (osr_tick[g]),
      .bit_tick  (bit_tick[g]),
      .osr_value (osr_value[g*8 +: 8])
    );
  end

endmodule

// File: tb/tb_uart_baud_gen_mc.sv
// Directed self-checking bench for uart_baud_gen_mc (4 channels, default widths).
module tb_uart_baud_gen_mc;

`ifdef UART_BAUD_FRAC_EN
  localparam int C1_GAP2   = 4;
  localparam int C1_BIT1   = 27;
  localparam int C1_BITGAP = 28;
`else
  localparam int C1_GAP2   = 3;
  localparam int C1_BIT1   = 24;
  localparam int C1_BITGAP = 24;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_div_int;
  logic [7:0]  cfg_div_frac;
  logic [3:0]  cfg_osr_sel;
  logic        cfg_err;
  logic [3:0]  cfg_pending;
  logic [3:0]  osr_tick;
  logic [3:0]  bit_tick;
  logic [31:0] osr_value;

  int edge_cnt = 0;
  int n_cmp    = 0;
  int n_err    = 0;

  uart_baud_gen_mc #(
    .NUM_CH      (4),
    .DIV_W       (16),
    .FRAC_W      (8),
    .DEFAULT_OSR (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_osr_sel  (cfg_osr_sel),
    .cfg_err      (cfg_err),
    .cfg_pending  (cfg_pending),
    .osr_tick     (osr_tick),
    .bit_tick     (bit_tick),
    .osr_value    (osr_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns the edge number of the next tick, or -1 if none within the budget.
  task automatic wait_tick(input int ch, input bit want_bit, output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((want_bit ? bit_tick[ch] : osr_tick[ch]) === 1'b1) begin
        at = edge_cnt;
        break;
      end
    end
  endtask

  // Issue one accepted write; returns at the negedge after the capture edge.
  task automatic do_cfg(input int ch, input int div, input int frac, input int sel);
    cfg_ch       = 3'(ch);
    cfg_div_int  = 16'(div);
    cfg_div_frac = 8'(frac);
    cfg_osr_sel  = 4'(sel);
    cfg_valid    = 1'b1;
    #1;
    check_val("cfg_ready_before_write", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached without finishing");
    $fatal(1);
  end

  initial begin
    int e, t1, t2, t3, b1, b2, t5;
    rst          = 1'b1;
    enable       = '0;
    cfg_valid    = 1'b0;
    cfg_ch       = '0;
    cfg_div_int  = '0;
    cfg_div_frac = '0;
    cfg_osr_sel  = '0;
    #1;
    check_val("rst_osr_tick", 32'(osr_tick), 32'd0);
    check_val("rst_bit_tick", 32'(bit_tick), 32'd0);
    check_val("rst_pending", 32'(cfg_pending), 32'd0);
    check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_val("rst_osr_value", osr_value, 32'h1010_1010);
    check_val("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ch0: div 4, OSR 4
    do_cfg(0, 4, 0, 2);
    check_val("c0_pending_set", 32'(cfg_pending[0]), 32'd1);
    check_val("c0_osr_still_active", 32'(osr_value[7:0]), 32'd16);
    @(negedge clk);
    check_val("c0_pending_idle_apply", 32'(cfg_pending[0]), 32'd0);
    check_val("c0_osr_applied", 32'(osr_value[7:0]), 32'd4);
    enable[0] = 1'b1;
    e = edge_cnt;
    wait_tick(0, 1'b0, t1);
    check_val("c0_first_osr", 32'(t1 - e), 32'd4);
    wait_tick(0, 1'b0, t2);
    check_val("c0_osr_gap", 32'(t2 - t1), 32'd4);
    wait_tick(0, 1'b1, b1);
    check_val("c0_first_bit", 32'(b1 - e), 32'd16);
    check_val("c0_bit_with_osr", 32'(osr_tick[0]), 32'd1);
    wait_tick(0, 1'b1, b2);
    check_val("c0_bit_gap", 32'(b2 - b1), 32'd16);
    enable[0] = 1'b0;

    // ch1: div 3.5, OSR 8
    do_cfg(1, 3, 128, 1);
    @(negedge clk);
    enable[1] = 1'b1;
    e = edge_cnt;
    wait_tick(1, 1'b0, t1);
    check_val("c1_first_osr", 32'(t1 - e), 32'd3);
    wait_tick(1, 1'b0, t2);
    check_val("c1_osr_gap1", 32'(t2 - t1), 32'd3);
    wait_tick(1, 1'b0, t3);
    check_val("c1_osr_gap2", 32'(t3 - t2), 32'(C1_GAP2));
    wait_tick(1, 1'b1, b1);
    check_val("c1_first_bit", 32'(b1 - e), 32'(C1_BIT1));
    wait_tick(1, 1'b1, b2);
    check_val("c1_bit_gap", 32'(b2 - b1), 32'(C1_BITGAP));
    enable[1] = 1'b0;

    // ch2: div 10 -> 5 written mid-bit
    do_cfg(2, 10, 0, 2);
    @(negedge clk);
    enable[2] = 1'b1;
    e = edge_cnt;
    wait_tick(2, 1'b0, t1);
    check_val("c2_first_osr", 32'(t1 - e), 32'd10);
    do_cfg(2, 5, 0, 2);
    check_val("c2_pending_set", 32'(cfg_pending[2]), 32'd1);
    #1;
    check_val("c2_ready_low", 32'(cfg_ready), 32'd0);
    wait_tick(2, 1'b0, t2);
    check_val("c2_old_gap1", 32'(t2 - t1), 32'd10);
    wait_tick(2, 1'b0, t3);
    check_val("c2_old_gap2", 32'(t3 - t2), 32'd10);
    check_val("c2_pending_held", 32'(cfg_pending[2]), 32'd1);
    wait_tick(2, 1'b1, b1);
    check_val("c2_bit_old_gap", 32'(b1 - t3), 32'd10);
    check_val("c2_pending_clear", 32'(cfg_pending[2]), 32'd0);
    wait_tick(2, 1'b0, t5);
    check_val("c2_new_gap", 32'(t5 - b1), 32'd5);
    enable[2] = 1'b0;

    // ch3: div 0 treated as 1, OSR 13
    do_cfg(3, 0, 0, 12);
    @(negedge clk);
    check_val("c3_osr_value", 32'(osr_value[31:24]), 32'd13);
    enable[3] = 1'b1;
    e = edge_cnt;
    wait_tick(3, 1'b0, t1);
    check_val("c3_first_osr", 32'(t1 - e), 32'd1);
    wait_tick(3, 1'b0, t2);
    check_val("c3_osr_gap", 32'(t2 - t1), 32'd1);
    wait_tick(3, 1'b1, b1);
    check_val("c3_first_bit", 32'(b1 - e), 32'd13);
    wait_tick(3, 1'b1, b2);
    check_val("c3_bit_gap", 32'(b2 - b1), 32'd13);
    enable[3] = 1'b0;

    // Write to a nonexistent channel
    @(negedge clk);
    cfg_ch      = 3'd6;
    cfg_div_int = 16'd9;
    cfg_valid   = 1'b1;
    #1;
    check_val("bad_ch_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check_val("bad_ch_err_pulse", 32'(cfg_err), 32'd1);
    check_val("bad_ch_no_pending", 32'(cfg_pending), 32'd0);
    check_val("bad_ch_osr_value", osr_value, 32'h0D04_0804);
    @(negedge clk);
    check_val("bad_ch_err_clear", 32'(cfg_err), 32'd0);

    // Reset mid-bit with a pending write on ch0
    enable[0] = 1'b1;
    e = edge_cnt;
    wait_tick(0, 1'b0, t1);
    check_val("r_first_osr", 32'(t1 - e), 32'd4);
    do_cfg(0, 7, 0, 2);
    check_val("r_pending_set", 32'(cfg_pending[0]), 32'd1);
    wait_tick(0, 1'b0, t2);
    check_val("r_second_osr", 32'(t2 - e), 32'd8);
    rst = 1'b1;
    #1;
    check_val("r_osr_tick_clear", 32'(osr_tick), 32'd0);
    check_val("r_bit_tick_clear", 32'(bit_tick), 32'd0);
    check_val("r_pending_clear", 32'(cfg_pending), 32'd0);
    check_val("r_osr_value", osr_value, 32'h1010_1010);
    @(negedge clk);
    rst = 1'b0;
    e = edge_cnt;
    wait_tick(0, 1'b0, t1);
    check_val("r_release_first", 32'(t1 - e), 32'd1);
    wait_tick(0, 1'b0, t2);
    check_val("r_release_gap", 32'(t2 - t1), 32'd1);
    check_val("r_pending_stays_clear", 32'(cfg_pending), 32'd0);
    check_val("r_osr_value_after", osr_value, 32'h1010_1010);
    enable = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
